lcd_frame_sequencer: RTL and testbench

- Upstream producer for the LCD byte interface. Emits 9-bit command/data words on a pull handshake.
- After reset it plays a fixed panel init sequence. Then, per frame, it sends the window setup (CASET/RASET/RAMWR) and streams RGB565 pixels as two data bytes each.
- Sits between the pixel source (rasterizer/framebuffer reader) and the LCD byte interface.

---
 rtl/lcd_frame_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_lcd_frame_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_sequencer.sv
// Producer for the LCD byte interface: panel init ROM, per-frame CASET/RASET/RAMWR window, RGB565 pixels as two data bytes.
// Optional macro LCD_UNDERRUN_CNT_EN adds underrun_count (filler NOPs pulled while streaming, saturating).
module lcd_frame_sequencer #(
  parameter int          WIDTH            = 240,
  parameter int          HEIGHT           = 320,
  parameter logic [15:0] INIT_DELAY_PULLS = 16'd30000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [15:0] pixel_data,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic [8:0]  lcd_command_data,
  input  logic        lcd_command_pull,
  output logic        init_done,
  output logic        busy,
  output logic        frame_done
`ifdef LCD_UNDERRUN_CNT_EN
  ,
  output logic [15:0] underrun_count
`endif
);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WINDOW, ST_STREAM} state_t;

  localparam logic [31:0] TOTAL = 32'(WIDTH * HEIGHT);
  localparam logic [15:0] EC    = 16'(WIDTH - 1);
  localparam logic [15:0] ER    = 16'(HEIGHT - 1);
  localparam logic [8:0]  NOP   = 9'h100;

  // Index 1 and 3 are the delay slots; they repeat INIT_DELAY_PULLS times.
  function automatic logic [8:0] init_word(input logic [3:0] i);
    case (i)
      4'd0:    init_word = 9'h101;
      4'd1:    init_word = NOP;
      4'd2:    init_word = 9'h111;
      4'd3:    init_word = NOP;
      4'd4:    init_word = 9'h13A;
      4'd5:    init_word = 9'h055;
      4'd6:    init_word = 9'h136;
      4'd7:    init_word = 9'h048;
      default: init_word = 9'h129;
    endcase
  endfunction

  function automatic logic [8:0] win_word(input logic [3:0] i);
    case (i)
      4'd0:    win_word = 9'h12A;
      4'd3:    win_word = {1'b0, EC[15:8]};
      4'd4:    win_word = {1'b0, EC[7:0]};
      4'd5:    win_word = 9'h12B;
      4'd8:    win_word = {1'b0, ER[15:8]};
      4'd9:    win_word = {1'b0, ER[7:0]};
      4'd10:   win_word = 9'h12C;
      default: win_word = 9'h000;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [8:0]  data_q, data_d;
  logic        filler_q, filler_d;
  logic        is_lo_q, is_lo_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] delay_q, delay_d;
  logic [15:0] hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [31:0] pix_cnt_q, pix_cnt_d;
  logic        init_done_q, init_done_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic        pixel_ready_q, pixel_ready_d;
  logic        retire, accept;
  logic [15:0] delay_inc;
  logic [31:0] pix_inc;
  logic [3:0]  idx_nxt;
`ifdef LCD_UNDERRUN_CNT_EN
  logic [15:0] underrun_q, underrun_d;
`endif

  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    filler_d      = filler_q;
    is_lo_d       = is_lo_q;
    idx_d         = idx_q;
    delay_d       = delay_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    pix_cnt_d     = pix_cnt_q;
    init_done_d   = init_done_q;
    frame_done_d  = 1'b0;
    retire        = lcd_command_pull & ~filler_q;
    accept        = pixel_valid & pixel_ready_q;
    delay_inc     = delay_q + 16'd1;
    pix_inc       = pix_cnt_q + 32'd1;
    idx_nxt       = idx_q + 4'd1;
    if (INIT_DELAY_PULLS == 16'd0 && (idx_nxt == 4'd1 || idx_nxt == 4'd3))
      idx_nxt = idx_q + 4'd2;
`ifdef LCD_UNDERRUN_CNT_EN
    underrun_d = underrun_q;
    if (state_q == ST_STREAM && filler_q && lcd_command_pull && underrun_q != 16'hFFFF)
      underrun_d = underrun_q + 16'd1;
`endif

    case (state_q)
      ST_INIT: begin
        if (filler_q) begin
          data_d   = init_word(idx_q);
          filler_d = 1'b0;
        end else if (retire) begin
          if (idx_q == 4'd8) begin
            init_done_d = 1'b1;
            state_d     = ST_IDLE;
            data_d      = NOP;
            filler_d    = 1'b1;
          end else if ((idx_q == 4'd1 || idx_q == 4'd3) && delay_inc != INIT_DELAY_PULLS) begin
            delay_d = delay_inc;
          end else begin
            delay_d = 16'd0;
            idx_d   = idx_nxt;
            data_d  = init_word(idx_nxt);
          end
        end
      end
      ST_IDLE: begin
        if (frame_start) begin
          state_d   = ST_WINDOW;
          idx_d     = 4'd0;
          pix_cnt_d = 32'd0;
        end
      end
      ST_WINDOW: begin
        if (filler_q) begin
          data_d   = win_word(idx_q);
          filler_d = 1'b0;
        end else if (retire) begin
          if (idx_q == 4'd10) begin
            state_d  = ST_STREAM;
            data_d   = NOP;
            filler_d = 1'b1;
            is_lo_d  = 1'b0;
`ifdef LCD_UNDERRUN_CNT_EN
            underrun_d = 16'd0;
`endif
          end else begin
            idx_d  = idx_q + 4'd1;
            data_d = win_word(idx_q + 4'd1);
          end
        end
      end
      default: begin
        // Accept only happens with the hold empty, i.e. while a filler sits in the output register.
        if (accept) begin
          hold_d      = pixel_data;
          hold_full_d = 1'b1;
          data_d      = {1'b0, pixel_data[15:8]};
          filler_d    = 1'b0;
          is_lo_d     = 1'b0;
        end else if (retire) begin
          if (!is_lo_q) begin
            data_d  = {1'b0, hold_q[7:0]};
            is_lo_d = 1'b1;
          end else begin
            hold_full_d = 1'b0;
            pix_cnt_d   = pix_inc;
            is_lo_d     = 1'b0;
            data_d      = NOP;
            filler_d    = 1'b1;
            if (pix_inc == TOTAL) begin
              frame_done_d = 1'b1;
              state_d      = ST_IDLE;
            end
          end
        end
      end
    endcase

    busy_d        = (state_d != ST_IDLE);
    pixel_ready_d = (state_d == ST_STREAM) & ~hold_full_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_INIT;
      data_q        <= NOP;
      filler_q      <= 1'b1;
      is_lo_q       <= 1'b0;
      idx_q         <= 4'd0;
      delay_q       <= 16'd0;
      hold_q        <= 16'd0;
      hold_full_q   <= 1'b0;
      pix_cnt_q     <= 32'd0;
      init_done_q   <= 1'b0;
      busy_q        <= 1'b1;
      frame_done_q  <= 1'b0;
      pixel_ready_q <= 1'b0;
`ifdef LCD_UNDERRUN_CNT_EN
      underrun_q    <= 16'd0;
`endif
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      filler_q      <= filler_d;
      is_lo_q       <= is_lo_d;
      idx_q         <= idx_d;
      delay_q       <= delay_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      pix_cnt_q     <= pix_cnt_d;
      init_done_q   <= init_done_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      pixel_ready_q <= pixel_ready_d;
`ifdef LCD_UNDERRUN_CNT_EN
      underrun_q    <= underrun_d;
`endif
    end
  end

  assign lcd_command_data = data_q;
  assign pixel_ready      = pixel_ready_q;
  assign init_done        = init_done_q;
  assign busy             = busy_q;
  assign frame_done       = frame_done_q;
`ifdef LCD_UNDERRUN_CNT_EN
  assign underrun_count   = underrun_q;
`endif

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Bench for lcd_frame_sequencer with a 4x2 panel and 2 delay NOPs: init/window word tables plus streaming corner cases.
module tb_lcd_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic [15:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready;
  logic [8:0]  lcd_command_data;
  logic        lcd_command_pull;
  logic        init_done;
  logic        busy;
  logic        frame_done;
`ifdef LCD_UNDERRUN_CNT_EN
  logic [15:0] underrun_count;
`endif

  always #5 clk = ~clk;

  lcd_frame_sequencer #(.WIDTH(4), .HEIGHT(2), .INIT_DELAY_PULLS(16'd2)) dut (
    .clk              (clk),
    .rst              (rst),
    .frame_start      (frame_start),
    .pixel_data       (pixel_data),
    .pixel_valid      (pixel_valid),
    .pixel_ready      (pixel_ready),
    .lcd_command_data (lcd_command_data),
    .lcd_command_pull (lcd_command_pull),
    .init_done        (init_done),
    .busy             (busy),
    .frame_done       (frame_done)
`ifdef LCD_UNDERRUN_CNT_EN
    ,
    .underrun_count   (underrun_count)
`endif
  );

  typedef struct {
    logic       fs;
    logic [8:0] word;
    logic       init_e;
    logic       busy_e;
  } vec_t;

  vec_t       vecs [22];
  int         checks = 0;
  int         errors = 0;
  int         fd_total = 0;
  logic [8:0] words [$];
  int         nops, done_pulses, done_cyc, last_pull, ready_pairs;

  always @(posedge clk) if (frame_done) fd_total++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input int i);
    logic [8:0] w;
    frame_start = vecs[i].fs;
    step();
    frame_start = 1'b0;
    step();
    step();
    lcd_command_pull = 1'b1;
    w = lcd_command_data;
    step();
    lcd_command_pull = 1'b0;
    chk($sformatf("vec%0d word", i), 32'(w), 32'(vecs[i].word));
    chk($sformatf("vec%0d init_done", i), 32'(init_done), 32'(vecs[i].init_e));
    chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].busy_e));
  endtask

  task automatic run_stream(input int ncyc, input int period, input int gap_s, input int gap_e,
                            input logic [15:0] base, input bit same);
    int  k;
    bit  acc;
    bit  prev_rdy;
    k = 0; prev_rdy = 0;
    words.delete();
    nops = 0; done_pulses = 0; done_cyc = -1; last_pull = -1; ready_pairs = 0;
    for (int c = 0; c < ncyc; c++) begin
      lcd_command_pull = ((c % period) == period - 1);
      pixel_valid      = !(c >= gap_s && c < gap_e);
      pixel_data       = same ? base : base + 16'(k);
      if (frame_done) begin done_pulses++; done_cyc = c; end
      if (pixel_ready && prev_rdy) ready_pairs++;
      prev_rdy = pixel_ready;
      acc = pixel_valid && pixel_ready;
      if (lcd_command_pull && busy) begin
        if (lcd_command_data == 9'h100) nops++;
        else begin words.push_back(lcd_command_data); last_pull = c; end
      end
      step();
      if (acc) k++;
    end
    lcd_command_pull = 1'b0;
    pixel_valid      = 1'b0;
  endtask

  task automatic check_words(input string nm, input int n, input logic [15:0] base, input bit same);
    logic [15:0] px;
    logic [8:0]  got, exp;
    chk({nm, " word count"}, 32'(words.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      px  = same ? base : base + 16'(i / 2);
      exp = (i % 2 == 0) ? {1'b0, px[15:8]} : {1'b0, px[7:0]};
      got = (i < words.size()) ? words[i] : 9'h1FF;
      chk($sformatf("%s word%0d", nm, i), 32'(got), 32'(exp));
    end
  endtask

  task automatic check_reset();
    chk("rst data", 32'(lcd_command_data), 32'h100);
    chk("rst pixel_ready", 32'(pixel_ready), 32'h0);
    chk("rst init_done", 32'(init_done), 32'h0);
    chk("rst busy", 32'(busy), 32'h1);
    chk("rst frame_done", 32'(frame_done), 32'h0);
  endtask

  initial begin
    // Init table (frame_start on two entries must be ignored), then window table for 4x2.
    vecs[0]  = '{1'b0, 9'h101, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 9'h100, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 9'h100, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 9'h111, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 9'h100, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 9'h100, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 9'h13A, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 9'h055, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 9'h136, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 9'h048, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 9'h129, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 9'h12A, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 9'h000, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 9'h000, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 9'h000, 1'b1, 1'b1};
    vecs[15] = '{1'b0, 9'h003, 1'b1, 1'b1};
    vecs[16] = '{1'b0, 9'h12B, 1'b1, 1'b1};
    vecs[17] = '{1'b0, 9'h000, 1'b1, 1'b1};
    vecs[18] = '{1'b0, 9'h000, 1'b1, 1'b1};
    vecs[19] = '{1'b0, 9'h000, 1'b1, 1'b1};
    vecs[20] = '{1'b0, 9'h001, 1'b1, 1'b1};
    vecs[21] = '{1'b0, 9'h12C, 1'b1, 1'b1};

    rst = 1'b1; frame_start = 1'b0; pixel_data = 16'h0; pixel_valid = 1'b0; lcd_command_pull = 1'b0;
    repeat (3) step();
    check_reset();
    rst = 1'b0;
    for (int i = 0; i < 11; i++) apply_vec(i);

    // Frame 1: constant pixel, sparse pulls, no underrun expected.
    for (int i = 11; i < 22; i++) apply_vec(i);
    run_stream(80, 4, 0, 0, 16'hF81F, 1'b1);
    check_words("f1", 16, 16'hF81F, 1'b1);
    chk("f1 nops", 32'(nops), 32'd0);
    chk("f1 done pulses", 32'(done_pulses), 32'd1);
    chk("f1 done cycle", 32'(done_cyc), 32'd64);
    chk("f1 done after last pull", 32'(done_cyc - last_pull), 32'd1);
    chk("f1 busy", 32'(busy), 32'd0);
    chk("f1 pixel_ready", 32'(pixel_ready), 32'd0);

    // Frame 2: pull every cycle, distinct pixels.
    for (int i = 11; i < 22; i++) apply_vec(i);
    run_stream(40, 1, 0, 0, 16'h1234, 1'b0);
    check_words("f2", 16, 16'h1234, 1'b0);
    chk("f2 nops", 32'(nops), 32'd8);
    chk("f2 done cycle", 32'(done_cyc), 32'd24);
    chk("f2 ready pairs", 32'(ready_pairs), 32'd0);

    // Frame 3: 12-cycle valid gap right after the second pixel's low byte.
    for (int i = 11; i < 22; i++) apply_vec(i);
    run_stream(100, 4, 16, 28, 16'h0A50, 1'b0);
    check_words("f3", 16, 16'h0A50, 1'b0);
    chk("f3 nops", 32'(nops), 32'd3);
    chk("f3 done cycle", 32'(done_cyc), 32'd76);
`ifdef LCD_UNDERRUN_CNT_EN
    chk("f3 underrun_count", 32'(underrun_count), 32'd3);
`endif

    // Frame 4: reset after three pixels, init reruns from SWRESET.
    for (int i = 11; i < 22; i++) apply_vec(i);
    run_stream(26, 4, 0, 0, 16'hA5C3, 1'b0);
    check_words("f4", 6, 16'hA5C3, 1'b0);
    chk("f4 done pulses", 32'(done_pulses), 32'd0);
    rst = 1'b1;
    repeat (2) step();
    check_reset();
    rst = 1'b0;
    for (int i = 0; i < 11; i++) apply_vec(i);
    chk("frame_done total", 32'(fd_total), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
